// File: rtl/des_pkg.sv
// Shared constants for the DES key schedule.
// Holds the PC-1 and PC-2 selection tables, the per-round shift schedule,
// the state encoding and the half-key / subkey widths.
// All tables list DES bit numbers (1-based) exactly as printed in FIPS 46-3.
// Vector index n always carries DES bit n+1.
package des_pkg;

    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    // PC-1: output bit i+1 (C = outputs 1..28, D = outputs 29..56) takes key bit PC1_TAB[i].
    localparam logic [5:0] PC1_TAB [0:55] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    // PC-2: subkey bit i+1 takes bit PC2_TAB[i] of the concatenated C||D.
    localparam logic [5:0] PC2_TAB [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Shift schedule S[1..16], stored 0-based: SHIFT_TAB[r] = S[r+1].
    localparam logic [1:0] SHIFT_TAB [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_pc2.sv
// DES PC-2 selection: picks 48 of the 56 C||D bits to form a round subkey.
// Ports:
//   halfKeys  in  56  {D, C}; index n = bit n+1 of C||D
//   subKey    out 48  index n = subkey bit n+1
// Pure wiring, no logic.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*HALF_W-1:0]  halfKeys,
    output logic [SUBKEY_W-1:0]  subKey
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : gSel
        assign subKey[i] = halfKeys[PC2_TAB[i] - 6'd1];
    end

    // C||D bits 9, 18, 22, 25, 35, 38, 43, 54 are dropped by PC-2.
    logic [7:0] unusedBits;
    assign unusedBits = {halfKeys[8],  halfKeys[17], halfKeys[21], halfKeys[24],
                         halfKeys[34], halfKeys[37], halfKeys[42], halfKeys[53]};

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator.
// Streams the sixteen 48-bit subkeys, one per SubKeyValid/SubKeyReady handshake.
// Encrypt emits K1..K16 (left rotations); decrypt emits K16..K1 (right rotations),
// so no key table is stored.
// Ports:
//   Clk          in   clock
//   Reset        in   async active-high reset
//   Start        in   1-cycle request, sampled only in IDLE
//   Mode         in   0 = encrypt, 1 = decrypt; latched with Start
//   Key          in   64-bit key, index n = DES bit n+1 (parity bits unused)
//   SubKeyReady  in   consumer accepts SubKey this cycle
//   SubKey       out  current subkey, index n = DES subkey bit n+1
//   SubKeyValid  out  SubKey/RoundNum valid
//   RoundNum     out  DES round number minus 1 for SubKey
//   Busy         out  run in progress (RUN or FIN)
//   Done         out  1-cycle pulse after the 16th accept
// Every output is decoded from registers only; SubKeyReady reaches only next-state logic.
module des_key_schedule
    import des_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Mode,
    input  logic [63:0]          Key,
    input  logic                 SubKeyReady,
    output logic [SUBKEY_W-1:0]  SubKey,
    output logic                 SubKeyValid,
    output logic [3:0]           RoundNum,
    output logic                 Busy,
    output logic                 Done
);

    logic [1:0]        state;
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    logic              modeDec;
    logic [4:0]        issueCnt;

    logic [2*HALF_W-1:0] pc1Key;
    logic [HALF_W-1:0]   pc1C;
    logic [HALF_W-1:0]   pc1D;
    logic [3:0]          shiftIdx;
    logic [1:0]          shiftAmt;

    // In index terms a DES left rotation moves bits toward index 0.
    function automatic logic [HALF_W-1:0] rotL(input logic [HALF_W-1:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotR(input logic [HALF_W-1:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    // PC-1 selection
    for (genvar i = 0; i < 2*HALF_W; i++) begin : gPc1
        assign pc1Key[i] = Key[PC1_TAB[i] - 6'd1];
    end
    assign pc1C = pc1Key[HALF_W-1:0];
    assign pc1D = pc1Key[2*HALF_W-1:HALF_W];

    // Parity bits never enter the schedule.
    logic unusedParity;
    assign unusedParity = ^{Key[7], Key[15], Key[23], Key[31], Key[39], Key[47], Key[55], Key[63]};

    // Decrypt counts rounds down: 15 - issueCnt == ~issueCnt[3:0].
    assign RoundNum = modeDec ? ~issueCnt[3:0] : issueCnt[3:0];

    // Encrypt moves to the next round (S[R+1]); decrypt undoes the current one (S[R]).
    // The wrap of RoundNum+1 on the final accept is harmless: the rotated value is never used.
    assign shiftIdx = modeDec ? RoundNum : RoundNum + 4'd1;
    assign shiftAmt = SHIFT_TAB[shiftIdx];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            c        <= '0;
            d        <= '0;
            modeDec  <= 1'b0;
            issueCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state    <= RUN;
                        modeDec  <= Mode;
                        issueCnt <= '0;
                        // C0/D0 already equal C16/D16, so decrypt loads unrotated.
                        if (Mode) begin
                            c <= pc1C;
                            d <= pc1D;
                        end else begin
                            c <= rotL(pc1C, SHIFT_TAB[0]);
                            d <= rotL(pc1D, SHIFT_TAB[0]);
                        end
                    end
                end
                RUN: begin
                    if (SubKeyReady) begin
                        issueCnt <= issueCnt + 5'd1;
                        if (modeDec) begin
                            c <= rotR(c, shiftAmt);
                            d <= rotR(d, shiftAmt);
                        end else begin
                            c <= rotL(c, shiftAmt);
                            d <= rotL(d, shiftAmt);
                        end
                        if (issueCnt == 5'd15)
                            state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign SubKeyValid = (state == RUN);
    assign Busy        = (state != IDLE);
    assign Done        = (state == FIN);

    des_pc2 uPc2 (
        .halfKeys ({d, c}),
        .subKey   (SubKey)
    );

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    logic        Clk = 1'b0;
    logic        Reset, Start, Mode, SubKeyReady;
    logic [63:0] Key;
    logic [47:0] SubKey;
    logic        SubKeyValid, Busy, Done;
    logic [3:0]  RoundNum;

    int asserts  = 0;
    int failures = 0;

    localparam logic [63:0] KP   = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1P  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16P = 48'hCB3D8B0E17F5;
    localparam logic [63:0] PARITY_MASK = 64'h8080808080808080;

    always #5 Clk = ~Clk;

    des_key_schedule dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Key(Key),
        .SubKeyReady(SubKeyReady), .SubKey(SubKey), .SubKeyValid(SubKeyValid),
        .RoundNum(RoundNum), .Busy(Busy), .Done(Done)
    );

    // Reference tables, textbook form (1-based DES bit numbers).
    int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int SHF [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] refKey [16];   // printed (DES-order) K1..K16
    logic [47:0] encSeq [16];
    logic [47:0] gotKey [16];
    logic [3:0]  gotRn  [16];
    int nAcc, doneCyc, stallErr;
    logic validFirst, busyFirst, validAfter, busyAfter, doneAfter;

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = v[47-i];
        return r;
    endfunction

    // Textbook key schedule on the printed (MSB = DES bit 1) representation.
    task automatic buildRef(input logic [63:0] keyP);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = keyP[64-PC1[i]];
            d[27-i] = keyP[64-PC1[i+28]];
        end
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHF[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2[j]];
            refKey[r] = k;
        end
    endtask

    // Starts a run and records the accepted subkeys. Cycle 1 is the cycle after the Start edge.
    task automatic runKey(input logic [63:0] k, input logic m, input int readyPct,
                          input int glitchCyc, input logic finStart);
        logic        prevStall, rdy;
        logic [47:0] prevKey;
        logic [3:0]  prevRn;
        nAcc = 0; doneCyc = -1; stallErr = 0; prevStall = 1'b0;
        prevKey = '0; prevRn = '0;
        @(negedge Clk);
        Start = 1'b1; Key = k; Mode = m; SubKeyReady = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        validFirst = SubKeyValid;
        busyFirst  = Busy;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (Done) begin
                doneCyc = cyc;
                break;
            end
            if (!SubKeyValid) stallErr++;
            else if (prevStall && (SubKey !== prevKey || RoundNum !== prevRn)) stallErr++;
            rdy = ($urandom_range(99) < readyPct);
            SubKeyReady = rdy;
            if (cyc == glitchCyc) begin
                Start = 1'b1; Key = ~k; Mode = ~m;
            end else begin
                Start = 1'b0;
            end
            if (SubKeyValid && rdy) begin
                if (nAcc < 16) begin
                    gotKey[nAcc] = SubKey;
                    gotRn[nAcc]  = RoundNum;
                end
                nAcc++;
            end
            prevStall = SubKeyValid && !rdy;
            prevKey   = SubKey;
            prevRn    = RoundNum;
            @(negedge Clk);
        end
        Start = finStart;
        SubKeyReady = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        validAfter = SubKeyValid;
        busyAfter  = Busy;
        doneAfter  = Done;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Key = '0; SubKeyReady = 1'b0;
        #12;
        asserts++; if (SubKey !== 48'h0) begin failures++; $display("FAIL reset_subkey: got %h want 0", SubKey); end
        asserts++; if (RoundNum !== 4'h0) begin failures++; $display("FAIL reset_roundnum: got %h want 0", RoundNum); end
        asserts++; if (SubKeyValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", SubKeyValid); end
        asserts++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", Busy); end
        asserts++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", Done); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_encrypt_vector;
        buildRef(KP);
        runKey(rev64(KP), 1'b0, 100, 0, 1'b0);
        asserts++; if (validFirst !== 1'b1 || busyFirst !== 1'b1) begin failures++; $display("FAIL enc_first_cycle: valid %b busy %b want 1 1", validFirst, busyFirst); end
        asserts++; if (doneCyc != 17) begin failures++; $display("FAIL enc_done_time: got %0d want 17", doneCyc); end
        asserts++; if (nAcc != 16) begin failures++; $display("FAIL enc_accepts: got %0d want 16", nAcc); end
        asserts++; if (rev48(gotKey[0]) !== K1P || gotRn[0] !== 4'd0) begin failures++; $display("FAIL enc_k1: got %h rn %0d want %h rn 0", rev48(gotKey[0]), gotRn[0], K1P); end
        asserts++; if (rev48(gotKey[15]) !== K16P || gotRn[15] !== 4'd15) begin failures++; $display("FAIL enc_k16: got %h rn %0d want %h rn 15", rev48(gotKey[15]), gotRn[15], K16P); end
        for (int i = 0; i < 16; i++) begin
            asserts++;
            if (rev48(gotKey[i]) !== refKey[i] || gotRn[i] !== 4'(i)) begin
                failures++; $display("FAIL enc_seq[%0d]: got %h rn %0d want %h rn %0d", i, rev48(gotKey[i]), gotRn[i], refKey[i], i);
            end
            encSeq[i] = gotKey[i];
        end
        asserts++; if (stallErr != 0) begin failures++; $display("FAIL enc_valid_hold: got %0d drops want 0", stallErr); end
        asserts++; if (busyAfter !== 1'b0 || validAfter !== 1'b0 || doneAfter !== 1'b0) begin failures++; $display("FAIL enc_idle_after: busy %b valid %b done %b want 0 0 0", busyAfter, validAfter, doneAfter); end
    endtask

    task automatic test_decrypt_vector;
        runKey(rev64(KP), 1'b1, 100, 0, 1'b0);
        asserts++; if (doneCyc != 17) begin failures++; $display("FAIL dec_done_time: got %0d want 17", doneCyc); end
        asserts++; if (rev48(gotKey[0]) !== K16P || gotRn[0] !== 4'd15) begin failures++; $display("FAIL dec_first: got %h rn %0d want %h rn 15", rev48(gotKey[0]), gotRn[0], K16P); end
        asserts++; if (rev48(gotKey[15]) !== K1P || gotRn[15] !== 4'd0) begin failures++; $display("FAIL dec_last: got %h rn %0d want %h rn 0", rev48(gotKey[15]), gotRn[15], K1P); end
        for (int i = 0; i < 16; i++) begin
            asserts++;
            if (gotKey[i] !== encSeq[15-i] || gotRn[i] !== 4'(15-i)) begin
                failures++; $display("FAIL dec_seq[%0d]: got %h rn %0d want %h rn %0d", i, gotKey[i], gotRn[i], encSeq[15-i], 15-i);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] k;
        logic m;
        int bad;
        for (int n = 0; n < 20; n++) begin
            k = {$urandom, $urandom};
            m = n[0];
            runKey(k, m, (n[1] ? 30 : 70), 0, 1'b0);
            buildRef(rev64(k));
            asserts++; if (nAcc != 16 || doneCyc < 17) begin failures++; $display("FAIL bp_accepts[%0d]: got %0d accepts done %0d want 16 done>=17", n, nAcc, doneCyc); end
            asserts++; if (stallErr != 0) begin failures++; $display("FAIL bp_stall[%0d]: got %0d unstable cycles want 0", n, stallErr); end
            bad = 0;
            for (int i = 0; i < 16; i++)
                if (rev48(gotKey[i]) !== refKey[m ? 15-i : i] || gotRn[i] !== 4'(m ? 15-i : i)) bad++;
            asserts++; if (bad != 0) begin failures++; $display("FAIL bp_seq[%0d]: got %0d wrong subkeys want 0 (key %h mode %b)", n, bad, k, m); end
        end
    endtask

    task automatic test_start_midrun;
        logic [63:0] k;
        int bad;
        for (int n = 0; n < 2; n++) begin
            k = rev64(KP) ^ {32'h0, $urandom};
            buildRef(rev64(k));
            runKey(k, n[0], 100, 3 + 4*n, 1'b0);
            asserts++; if (doneCyc != 17 || nAcc != 16) begin failures++; $display("FAIL midstart_timing[%0d]: done %0d accepts %0d want 17 16", n, doneCyc, nAcc); end
            bad = 0;
            for (int i = 0; i < 16; i++)
                if (rev48(gotKey[i]) !== refKey[n[0] ? 15-i : i]) bad++;
            asserts++; if (bad != 0) begin failures++; $display("FAIL midstart_seq[%0d]: got %0d wrong subkeys want 0", n, bad); end
        end
    endtask

    task automatic test_reset_midrun;
        int bad;
        @(negedge Clk);
        Start = 1'b1; Key = rev64(KP); Mode = 1'b0;
        @(negedge Clk);
        Start = 1'b0; SubKeyReady = 1'b1;
        repeat (7) @(negedge Clk);
        asserts++; if (RoundNum !== 4'd7 || SubKeyValid !== 1'b1) begin failures++; $display("FAIL rstmid_pre: rn %0d valid %b want 7 1", RoundNum, SubKeyValid); end
        #2 Reset = 1'b1;
        #1;
        asserts++; if (SubKey !== 48'h0 || RoundNum !== 4'h0) begin failures++; $display("FAIL rstmid_data: subkey %h rn %0d want 0 0", SubKey, RoundNum); end
        asserts++; if (SubKeyValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl: valid %b busy %b done %b want 0 0 0", SubKeyValid, Busy, Done); end
        SubKeyReady = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        asserts++; if (Done !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL rstmid_nodone: done %b busy %b want 0 0", Done, Busy); end
        buildRef(KP);
        runKey(rev64(KP), 1'b0, 100, 0, 1'b0);
        asserts++; if (doneCyc != 17 || nAcc != 16) begin failures++; $display("FAIL rstmid_rerun: done %0d accepts %0d want 17 16", doneCyc, nAcc); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (rev48(gotKey[i]) !== refKey[i]) bad++;
        asserts++; if (bad != 0) begin failures++; $display("FAIL rstmid_seq: got %0d wrong subkeys want 0", bad); end
    endtask

    task automatic test_parity;
        logic [63:0] k;
        int bad;
        runKey(rev64(KP) ^ PARITY_MASK, 1'b0, 100, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (gotKey[i] !== encSeq[i]) bad++;
        asserts++; if (bad != 0) begin failures++; $display("FAIL parity_vec: got %0d differing subkeys want 0", bad); end
        k = {$urandom, $urandom};
        buildRef(rev64(k));
        runKey(k ^ PARITY_MASK, 1'b1, 60, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rev48(gotKey[i]) !== refKey[15-i]) bad++;
        asserts++; if (bad != 0) begin failures++; $display("FAIL parity_rand: got %0d differing subkeys want 0", bad); end
    endtask

    task automatic test_back_to_back;
        int bad;
        // Start raised in the Done cycle lands in FIN and must be dropped.
        runKey(rev64(KP), 1'b1, 100, 0, 1'b1);
        asserts++; if (validAfter !== 1'b0 || busyAfter !== 1'b0) begin failures++; $display("FAIL fin_start: valid %b busy %b want 0 0", validAfter, busyAfter); end
        @(negedge Clk);
        asserts++; if (SubKeyValid !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL fin_start_idle: valid %b busy %b want 0 0", SubKeyValid, Busy); end
        buildRef(KP);
        runKey(rev64(KP), 1'b0, 100, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rev48(gotKey[i]) !== refKey[i]) bad++;
        asserts++; if (doneCyc != 17 || bad != 0) begin failures++; $display("FAIL restart: done %0d wrong %0d want 17 0", doneCyc, bad); end
    endtask

    initial begin
        test_reset;
        test_encrypt_vector;
        test_decrypt_vector;
        test_backpressure;
        test_start_midrun;
        test_reset_midrun;
        test_parity;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", failures);
        $fatal(1, "timeout");
    end

endmodule
